// File: rtl/instr_mem_sync.sv
// Registered instruction memory for the fetch stage: one-entry output register with
// valid/ready handshake, program-load write port and sticky fetch-fault record.
module instr_mem_sync #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    MEM_SIZE   = 1024,
    parameter int                    ADDR_WIDTH = $clog2(MEM_SIZE),
    parameter int                    PC_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_req_i,
    input  logic [PC_WIDTH-1:0]   fetch_addr_i,
    input  logic                  fetch_ready_i,
    input  logic                  flush_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_valid_o,
    output logic [DATA_WIDTH-1:0] fetch_instr_o,
    output logic [PC_WIDTH-1:0]   fetch_pc_o,
    output logic                  fetch_err_o,
    input  logic                  load_we_i,
    input  logic [PC_WIDTH-1:0]   load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_err_o,
    output logic                  err_sticky_o,
    output logic [PC_WIDTH-1:0]   err_addr_o
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_SIZE);

    // Misaligned, beyond the word-index field, or past the end of a non-power-of-two array.
    function automatic logic addr_fault(input logic [PC_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] idx;
        idx = {1'b0, a[ADDR_WIDTH+1:2]};
        return (a[1:0] != 2'b00) || ((a >> (ADDR_WIDTH + 2)) != '0) || (idx >= DEPTH);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE] = '{default: '0};

    state_t                state_p1, state_nxt;
    logic [DATA_WIDTH-1:0] instr_p1;
    logic [PC_WIDTH-1:0]   pc_p1;
    logic                  err_p1;
    logic                  load_err_p1;
    logic                  sticky_q;
    logic [PC_WIDTH-1:0]   err_addr_q;

    logic                  vld_p1;
    logic                  fetch_fault;
    logic                  load_fault;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic [ADDR_WIDTH-1:0] load_idx;

    assign fetch_idx   = fetch_addr_i[ADDR_WIDTH+1:2];
    assign load_idx    = load_addr_i[ADDR_WIDTH+1:2];
    assign fetch_fault = addr_fault(fetch_addr_i);
    assign load_fault  = addr_fault(load_addr_i);
    assign vld_p1      = (state_p1 == FULL);
    assign fetch_gnt_o = fetch_req_i & ~flush_i & (~vld_p1 | fetch_ready_i);

    always_comb begin
        state_nxt = state_p1;
        if (flush_i)
            state_nxt = EMPTY;
        else if (fetch_gnt_o)
            state_nxt = FULL;
        else if (vld_p1 && fetch_ready_i)
            state_nxt = EMPTY;
    end

    // Write port: independent of reset so a boot load survives a core reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i && !load_fault)
            mem[load_idx] <= load_data_i;
    end

    // Output register stage (p1): read-before-write against the load port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1    <= EMPTY;
            instr_p1    <= NOP_INSTR;
            pc_p1       <= '0;
            err_p1      <= 1'b0;
            load_err_p1 <= 1'b0;
            sticky_q    <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_p1    <= state_nxt;
            load_err_p1 <= load_we_i & load_fault;
            if (fetch_gnt_o) begin
                instr_p1 <= fetch_fault ? NOP_INSTR : mem[fetch_idx];
                pc_p1    <= fetch_addr_i;
                err_p1   <= fetch_fault;
                if (fetch_fault && !sticky_q) begin
                    sticky_q   <= 1'b1;
                    err_addr_q <= fetch_addr_i;
                end
            end
        end
    end

    assign fetch_valid_o = vld_p1;
    assign fetch_instr_o = instr_p1;
    assign fetch_pc_o    = pc_p1;
    assign fetch_err_o   = err_p1;
    assign load_err_o    = load_err_p1;
    assign err_sticky_o  = sticky_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed test-plan steps followed by random traffic,
// all checked against a transaction-level model of the fetch/load behaviour.
module tb_instr_mem_sync;

    localparam int DW = 16;
    localparam int MS = 1024;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst, req, ready, flush, we;
    logic [PW-1:0] addr, laddr;
    logic [DW-1:0] ldata;
    logic          gnt, valid, err, lerr, sticky;
    logic [DW-1:0] instr;
    logic [PW-1:0] pc, eaddr;

    instr_mem_sync #(
        .DATA_WIDTH(DW), .MEM_SIZE(MS), .PC_WIDTH(PW), .NOP_INSTR('0)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_req_i(req), .fetch_addr_i(addr), .fetch_ready_i(ready), .flush_i(flush),
        .fetch_gnt_o(gnt), .fetch_valid_o(valid), .fetch_instr_o(instr),
        .fetch_pc_o(pc), .fetch_err_o(err),
        .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata), .load_err_o(lerr),
        .err_sticky_o(sticky), .err_addr_o(eaddr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_mem [MS];
    bit m_valid = 0, m_err = 0, m_lerr = 0, m_sticky = 0;
    int m_instr = 0, m_pc = 0, m_eaddr = 0;

    function automatic bit faulty(input int a);
        return ((a % 4) != 0) || ((a / 4) >= MS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit q, input int a, input bit rd, input bit fl,
                       input bit w, input int la, input int ld);
        bit e_gnt;
        int rdata;
        rst = r; req = q; addr = a[PW-1:0]; ready = rd; flush = fl;
        we = w; laddr = la[PW-1:0]; ldata = ld[DW-1:0];
        #1;
        e_gnt = q && !fl && (!m_valid || rd);
        chk("gnt", {31'b0, gnt}, {31'b0, e_gnt});
        @(posedge clk);
        rdata = faulty(a) ? 0 : m_mem[a / 4];
        if (w && !faulty(la)) m_mem[la / 4] = ld & 'hFFFF;
        if (r) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_err = 0;
            m_lerr = 0; m_sticky = 0; m_eaddr = 0;
        end else begin
            m_lerr = w && faulty(la);
            if (e_gnt) begin
                m_valid = 1; m_instr = rdata; m_pc = a; m_err = faulty(a);
                if (faulty(a) && !m_sticky) begin
                    m_sticky = 1; m_eaddr = a;
                end
            end else if (fl || (m_valid && rd)) begin
                m_valid = 0;
            end
        end
        #1;
        chk("valid",  {31'b0, valid},  {31'b0, m_valid});
        chk("instr",  {16'b0, instr},  m_instr);
        chk("pc",     {16'b0, pc},     m_pc);
        chk("err",    {31'b0, err},    {31'b0, m_err});
        chk("lerr",   {31'b0, lerr},   {31'b0, m_lerr});
        chk("sticky", {31'b0, sticky}, {31'b0, m_sticky});
        chk("eaddr",  {16'b0, eaddr},  m_eaddr);
    endtask

    initial begin
        for (int i = 0; i < MS; i++) m_mem[i] = 0;

        // Reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_instr", {16'b0, instr}, 0);

        // Program load and back-to-back fetch
        cyc(0, 0, 0, 1, 0, 1, 'h0, 'h1911);
        cyc(0, 0, 0, 1, 0, 1, 'h4, 'h0460);
        cyc(0, 0, 0, 1, 0, 1, 'h8, 'h008A);
        cyc(0, 0, 0, 1, 0, 1, 'hC, 'h0093);
        cyc(0, 1, 'h0, 1, 0, 0, 0, 0); chk("b2b0", {16'b0, instr}, 'h1911);
        cyc(0, 1, 'h4, 1, 0, 0, 0, 0); chk("b2b1", {16'b0, instr}, 'h0460);
        cyc(0, 1, 'h8, 1, 0, 0, 0, 0); chk("b2b2", {16'b0, instr}, 'h008A);
        cyc(0, 1, 'hC, 1, 0, 0, 0, 0); chk("b2b3", {16'b0, instr}, 'h0093);

        // Stall: hold 0x4 with ready low while another request waits
        cyc(0, 1, 'h4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 'h8, 0, 0, 0, 0, 0);
            chk("stall_gnt", {31'b0, gnt}, 0);
            chk("stall_instr", {16'b0, instr}, 'h0460);
            chk("stall_pc", {16'b0, pc}, 'h4);
        end
        cyc(0, 1, 'h8, 1, 0, 0, 0, 0);
        chk("unstall", {16'b0, instr}, 'h008A);

        // Flush while full, with a competing request
        cyc(0, 1, 'h0, 0, 1, 0, 0, 0);
        chk("flush_valid", {31'b0, valid}, 0);

        // Faulting fetches
        cyc(0, 1, 'h0002, 1, 0, 0, 0, 0); chk("flt0", {16'b0, instr}, 0);
        cyc(0, 1, 'h1000, 1, 0, 0, 0, 0); chk("flt1", {31'b0, err}, 1);
        cyc(0, 1, 'hFFFC, 1, 0, 0, 0, 0); chk("flt2", {16'b0, instr}, 0);
        chk("flt_eaddr", {16'b0, eaddr}, 'h0002);

        // Dropped load write, then memory unchanged at the aliased word
        cyc(0, 0, 0, 1, 0, 1, 'h1000, 'h5555);
        chk("load_err", {31'b0, lerr}, 1);
        cyc(0, 1, 'h0, 1, 0, 0, 0, 0);
        chk("load_err_clr", {31'b0, lerr}, 0);
        chk("mem_keep", {16'b0, instr}, 'h1911);

        // Same-word collision: read-before-write
        cyc(0, 1, 'h8, 1, 0, 1, 'h8, 'hBEEF); chk("coll_old", {16'b0, instr}, 'h008A);
        cyc(0, 1, 'h8, 1, 0, 0, 0, 0);        chk("coll_new", {16'b0, instr}, 'hBEEF);

        // Reset while full and stalled
        cyc(0, 1, 'h4, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 'hC, 0, 0, 0, 0, 0);
        chk("rst_hold_valid", {31'b0, valid}, 0);
        chk("rst_hold_sticky", {31'b0, sticky}, 0);
        cyc(0, 1, 'h0, 1, 0, 0, 0, 0);
        chk("rst_mem", {16'b0, instr}, 'h1911);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int a, la;
            a  = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, 15) : $urandom_range(0, 'hFFFF);
            la = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, 15) : $urandom_range(0, 'hFFFF);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, a,
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) == 0, la, $urandom_range(0, 'hFFFF));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Synchronous, parametrised instruction memory for the riscv-mini fetch stage. Replaces the combinational lookup with a registered read port that has a valid/ready handshake and a one-entry output register, so fetch can stall and flush cleanly. Adds a write-only program-load port for the testbench or boot loader, plus out-of-range/misalignment detection with a sticky error record. Sits between the PC register and the decode stage.

## Interface
- `DATA_WIDTH`, 16: instruction width in bits.
- `MEM_SIZE`, 1024: depth in words; need not be a power of two.
- `ADDR_WIDTH`, `$clog2(MEM_SIZE)`: word-index width.
- `PC_WIDTH`, 16: byte-address width; must be ≥ `ADDR_WIDTH+2`.
- `NOP_INSTR`, `'0`: value returned for faulting fetches.

- `clk_i` input 1: single clock; all logic is on the rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `fetch_req_i` input 1: fetch request.
- `fetch_addr_i` input PC_WIDTH: byte address of the fetch.
- `fetch_ready_i` input 1: consumer accepts the output this cycle.
- `flush_i` input 1: discard held and in-flight fetch.
- `fetch_gnt_o` output 1: request accepted this cycle.
- `fetch_valid_o` output 1: output register holds an instruction.
- `fetch_instr_o` output DATA_WIDTH: fetched instruction.
- `fetch_pc_o` output PC_WIDTH: address belonging to `fetch_instr_o`.
- `fetch_err_o` output 1: the held fetch faulted.
- `load_we_i` input 1: program-load write strobe.
- `load_addr_i` input PC_WIDTH: byte address of the load write.
- `load_data_i` input DATA_WIDTH: word to write.
- `load_err_o` output 1: one-cycle pulse when a load write is dropped.
- `err_sticky_o` output 1: a fetch fault has occurred since reset.
- `err_addr_o` output PC_WIDTH: address of the first faulting fetch.

## Operation
- Word index = `addr[ADDR_WIDTH+1:2]`. The PC stride is 4 bytes per instruction.
- An address is faulting if any of these hold:
  - `addr[1:0] != 0`;
  - any bit of `addr[PC_WIDTH-1:ADDR_WIDTH+2]` is set;
  - word index ≥ `MEM_SIZE`.
- Output register FSM has two states:
  - EMPTY: `fetch_valid_o` = 0.
  - FULL: `fetch_valid_o` = 1.
- Grant: `fetch_gnt_o = fetch_req_i & ~flush_i & (~fetch_valid_o | fetch_ready_i)`. Combinational.
- On grant, the next edge loads the output register and the FSM goes to FULL:
  - `fetch_instr_o` = mem[idx], or `NOP_INSTR` if the address faults;
  - `fetch_pc_o` = `fetch_addr_i`;
  - `fetch_err_o` = fault flag.
- FULL with `fetch_ready_i`=1 and no grant: the FSM goes to EMPTY.
- FULL with `fetch_ready_i`=0: all fetch outputs are held bit-stable.
- `flush_i`=1: the next state is EMPTY regardless of request or ready. A same-cycle request is not granted.
- Load writes:
  - On `load_we_i`, mem[idx] ← `load_data_i` if the address is non-faulting.
  - Otherwise nothing is written and `load_err_o` pulses for 1 cycle (registered).
- Simultaneous load write and granted fetch to the same word: the fetch returns the old data (read-before-write).
- Sticky error: on the first granted faulting fetch, `err_sticky_o` ← 1 and `err_addr_o` ← `fetch_addr_i`. Later faults do not overwrite them. Only `rst_i` clears them.
- Memory array:
  - not affected by `rst_i`;
  - zero-initialised at time 0 for simulation;
  - must infer block RAM: one read port, one write port.

## Timing
- Fetch latency is 1 cycle: granted at edge N, data valid after edge N.
- Back-to-back fetches with `fetch_ready_i`=1 sustain 1 instruction per cycle.
- Load-to-fetch: a write at edge N is visible to a fetch granted at edge N+1 or later.
- Reset values:
  - FSM = EMPTY;
  - `fetch_valid_o`=0, `fetch_err_o`=0;
  - `fetch_instr_o`=`NOP_INSTR`, `fetch_pc_o`=0;
  - `load_err_o`=0;
  - `err_sticky_o`=0, `err_addr_o`=0.
- `rst_i` mid-operation:
  - a held instruction is dropped;
  - a same-cycle grant has no effect;
  - a same-cycle load write is still performed if the address is in range.
- `fetch_gnt_o` is combinational. All other outputs are registered.

## Test plan
- Load and fetch:
  - Load words 0..3 with 0x1911, 0x0460, 0x008A, 0x0093.
  - Fetch 0x0, 0x4, 0x8, 0xC back-to-back with ready=1.
  - Required: valid=1 on four consecutive cycles with those instructions, one cycle after each grant.
- Stall:
  - Fetch 0x4 while ready=0 for 3 cycles.
  - Required: valid, instr 0x0460 and pc 0x4 held stable; gnt=0 for a second request.
  - Then ready=1: gnt=1 and the new data follows next cycle.
- Flush:
  - While FULL, assert flush_i together with req.
  - Required: gnt=0, and valid=0 the next cycle.
- Faults:
  - Fetch 0x0002, then 0x1000, then 0xFFFC (MEM_SIZE=1024).
  - Required: each gives instr=0x0000 and err=1; `err_sticky_o`=1 and `err_addr_o`=0x0002 is retained.
- Load errors and same-word collision:
  - A load write to 0x1000 pulses `load_err_o` and leaves memory unchanged.
  - A same-cycle load of 0xBEEF to 0x8 plus a fetch of 0x8 returns 0x008A.
  - The next fetch of 0x8 returns 0xBEEF.
- Reset mid-hold:
  - Assert rst_i while FULL and stalled.
  - Required: valid=0, err_sticky_o=0 and err_addr_o=0 next cycle; memory contents preserved, so a fetch of 0x0 returns 0x1911.
